cpu_mult_pipe: RTL

Parametrised, fully pipelined integer multiplier for the worker CPU's M stage, replacing the fixed three-partial-product 32-bit multiply cell. It builds a DATA_W×DATA_W product from LIMB_W×LIMB_W limb products, computes all four Nios-style multiply variants (low; high signed×signed; high signed×unsigned; high unsigned×unsigned), and carries a destination tag. It sits between the E-stage operand latch and M-stage writeback, using a valid/ready handshake with a global stall and flush.

---
 rtl/cpu_mult_pkg.sv | 31 +++
 rtl/cpu_mult_limb.sv | 35 +++
 rtl/cpu_mult_pipe.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_mult_pkg.sv
// Shared definitions for the pipelined M-stage multiplier.
//   mult_op_e      : operation select (low product / three high-half variants)
//   num_limbs()    : limbs per operand for a given operand and limb width
//   prod_w()       : width of the full double-length product
//   is_signed_a/b  : which operands a given op interprets as two's complement
package cpu_mult_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULXSS = 2'd1,
    MULXSU = 2'd2,
    MULXUU = 2'd3
  } mult_op_e;

  function automatic int num_limbs(input int data_w, input int limb_w);
    return data_w / limb_w;
  endfunction

  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic logic is_signed_a(input mult_op_e op);
    return (op == MULXSS) || (op == MULXSU);
  endfunction

  function automatic logic is_signed_b(input mult_op_e op);
    return (op == MULXSS);
  endfunction

endpackage

// File: rtl/cpu_mult_limb.sv
// Registered LIMB_W x LIMB_W unsigned multiplier, one hard DSP multiplier.
//   clk : clock
//   clr : synchronous clear of the product register (wins over ce)
//   ce  : clock enable; product register holds when low
//   a,b : unsigned limb operands
//   p   : registered 2*LIMB_W-bit product
module cpu_mult_limb #(
  parameter int LIMB_W = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  ce,
  input  logic [LIMB_W-1:0]     a,
  input  logic [LIMB_W-1:0]     b,
  output logic [2*LIMB_W-1:0]   p
);

  logic [2*LIMB_W-1:0] p_d, p_q;

  always_comb begin
    p_d = p_q;
    if (clr) begin
      p_d = '0;
    end else if (ce) begin
      p_d = {{LIMB_W{1'b0}}, a} * {{LIMB_W{1'b0}}, b};
    end
  end

  always_ff @(posedge clk) begin
    p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/cpu_mult_pipe.sv
// Three-stage pipelined integer multiplier for the CPU M stage.
// Builds the full product from unsigned limb products, then derives the low
// half or one of three high-half variants with a signed correction.
//   clk, reset_n        : clock, synchronous active-low reset
//   flush               : kills every in-flight operation on the next edge
//   in_valid/in_ready   : operand handshake (in_ready = pipeline advances)
//   in_op, in_a, in_b   : operation select and operands
//   in_tag              : sideband tag returned with the result
//   out_valid/out_ready : result handshake
//   out_result, out_tag : selected product half and its tag
module cpu_mult_pipe
  import cpu_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LIMB_W = 16,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int N   = num_limbs(DATA_W, LIMB_W);
  localparam int PW  = prod_w(DATA_W);
  localparam int PPW = 2 * LIMB_W;

  // High half of a signed product from the unsigned one: a negative operand
  // contributes an extra -(other operand) << DATA_W to the unsigned product.
  function automatic logic [DATA_W-1:0] hi_correct(
    input logic [DATA_W-1:0] hi_u,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input mult_op_e          op
  );
    logic [DATA_W-1:0] corr_a;
    logic [DATA_W-1:0] corr_b;
    corr_a = (is_signed_a(op) && a[DATA_W-1]) ? b : '0;
    corr_b = (is_signed_b(op) && b[DATA_W-1]) ? a : '0;
    return hi_u - corr_a - corr_b;
  endfunction

  logic advance;

  logic              vld_p1_d, vld_p1_q;
  logic [DATA_W-1:0] a_p1_d, a_p1_q;
  logic [DATA_W-1:0] b_p1_d, b_p1_q;
  mult_op_e          op_p1_d, op_p1_q;
  logic [TAG_W-1:0]  tag_p1_d, tag_p1_q;

  logic              vld_p2_d, vld_p2_q;
  logic [DATA_W-1:0] a_p2_d, a_p2_q;
  logic [DATA_W-1:0] b_p2_d, b_p2_q;
  mult_op_e          op_p2_d, op_p2_q;
  logic [TAG_W-1:0]  tag_p2_d, tag_p2_q;
  logic [PPW-1:0]    pp_p2 [N*N];

  logic              vld_p3_d, vld_p3_q;
  logic [DATA_W-1:0] res_p3_d, res_p3_q;
  logic [TAG_W-1:0]  tag_p3_d, tag_p3_q;

  logic [PW-1:0]     sum_u;
  logic [DATA_W-1:0] res_sel;

  // Global stall: every stage moves together or not at all.
  assign advance    = !vld_p3_q || out_ready;
  assign in_ready   = advance;
  assign out_valid  = vld_p3_q;
  assign out_result = res_p3_q;
  assign out_tag    = tag_p3_q;

  always_comb begin
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    vld_p3_d = vld_p3_q;
    if (flush) begin
      vld_p1_d = 1'b0;
      vld_p2_d = 1'b0;
      vld_p3_d = 1'b0;
    end else if (advance) begin
      vld_p1_d = in_valid;
      vld_p2_d = vld_p1_q;
      vld_p3_d = vld_p2_q;
    end
  end

  // ---- S1: operand latch ----
  // ---- S2: limb products; operands ride along for the sign correction ----
  always_comb begin
    a_p1_d   = a_p1_q;
    b_p1_d   = b_p1_q;
    op_p1_d  = op_p1_q;
    tag_p1_d = tag_p1_q;
    a_p2_d   = a_p2_q;
    b_p2_d   = b_p2_q;
    op_p2_d  = op_p2_q;
    tag_p2_d = tag_p2_q;
    if (advance) begin
      a_p1_d   = in_a;
      b_p1_d   = in_b;
      op_p1_d  = mult_op_e'(in_op);
      tag_p1_d = in_tag;
      a_p2_d   = a_p1_q;
      b_p2_d   = b_p1_q;
      op_p2_d  = op_p1_q;
      tag_p2_d = tag_p1_q;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      cpu_mult_limb #(.LIMB_W(LIMB_W)) u_limb (
        .clk (clk),
        .clr (!reset_n),
        .ce  (advance),
        .a   (a_p1_q[gi*LIMB_W +: LIMB_W]),
        .b   (b_p1_q[gj*LIMB_W +: LIMB_W]),
        .p   (pp_p2[gi*N+gj])
      );
    end
  end

  // ---- S3: summation, correction, half select ----
  always_comb begin
    sum_u = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum_u = sum_u + (PW'(pp_p2[i*N+j]) << (LIMB_W * (i + j)));
      end
    end
    if (op_p2_q == MUL) begin
      res_sel = sum_u[DATA_W-1:0];
    end else begin
      res_sel = hi_correct(sum_u[PW-1:DATA_W], a_p2_q, b_p2_q, op_p2_q);
    end
  end

  always_comb begin
    res_p3_d = res_p3_q;
    tag_p3_d = tag_p3_q;
    if (advance) begin
      res_p3_d = res_sel;
      tag_p3_d = tag_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      res_p3_q <= '0;
      tag_p3_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
      res_p3_q <= res_p3_d;
      tag_p3_q <= tag_p3_d;
    end
  end

  always_ff @(posedge clk) begin
    a_p1_q   <= a_p1_d;
    b_p1_q   <= b_p1_d;
    op_p1_q  <= op_p1_d;
    tag_p1_q <= tag_p1_d;
    a_p2_q   <= a_p2_d;
    b_p2_q   <= b_p2_d;
    op_p2_q  <= op_p2_d;
    tag_p2_q <= tag_p2_d;
  end

endmodule
